pkt_ingress_ctrl: RTL and testbench

PKT_INGRESS_CTRL -- requirements
Module: pkt_ingress_ctrl

---
 rtl/pkt_ingress_ctrl.sv | 146 ++++++++++++++
 tb/tb_pkt_ingress_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ingress_ctrl.sv
// pkt_ingress_ctrl: stream ingress controller. Accepts one packet at a time
// into a downstream packet buffer, truncates packets longer than DEPTH words,
// then requests buffer readout and waits for the buffer to drain.
module pkt_ingress_ctrl #(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 8,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic               buf_w_req_o,
    output logic [DATA_W-1:0]  buf_w_data_o,
    output logic               buf_r_req_o,
    input  logic               buf_empty_i,
    output logic [DEPTH_W-1:0] pkt_len_o,
    output logic               pkt_done_o,
    output logic               ovf_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_COMMIT,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DEPTH_W-1:0] r_len;
    logic               r_trunc;
    logic               w_accept;
    logic               w_room;
    logic               w_write;
    logic               w_commit;
    logic               w_enter_idle;

    assign w_accept     = s_axis_tvalid & s_axis_tready;
    assign w_room       = (r_len < DEPTH_W'(DEPTH));
    // First beat always fits; later beats only while below DEPTH words.
    assign w_write      = w_accept & ((r_state == ST_IDLE) |
                                      ((r_state == ST_ACCEPT) & w_room));
    assign w_commit     = (r_state == ST_COMMIT);
    assign w_enter_idle = (r_state == ST_DRAIN) & (w_state_nxt == ST_IDLE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the drain exit ignores the readout-request cycle
    // because the buffer cannot have reacted to it yet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = s_axis_tlast ? ST_COMMIT : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!buf_r_req_o && buf_empty_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ready decode from registered state (and buffer status) only
    always_comb begin
        s_axis_tready = 1'b0;
        case (r_state)
            ST_IDLE:   s_axis_tready = buf_empty_i;
            ST_ACCEPT: s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    // Packet length counter (saturating) and sticky truncation flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (w_enter_idle) begin
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_len <= DEPTH_W'(1);
        end else if (w_accept && (r_state == ST_ACCEPT)) begin
            if (w_room) begin
                r_len <= r_len + DEPTH_W'(1);
            end else begin
                r_trunc <= 1'b1;
            end
        end
    end

    // Registered buffer write port; data holds when nothing is written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_w_req_o  <= 1'b0;
            buf_w_data_o <= '0;
        end else begin
            buf_w_req_o <= w_write;
            if (w_write) begin
                buf_w_data_o <= s_axis_tdata;
            end
        end
    end

    // Commit pulses and held packet length, issued the cycle after ST_COMMIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_r_req_o <= 1'b0;
            pkt_done_o  <= 1'b0;
            ovf_err_o   <= 1'b0;
            pkt_len_o   <= '0;
        end else begin
            buf_r_req_o <= w_commit;
            pkt_done_o  <= w_commit;
            ovf_err_o   <= w_commit & r_trunc;
            if (w_commit) begin
                pkt_len_o <= r_len;
            end
        end
    end

endmodule

// File: tb/tb_pkt_ingress_ctrl.sv
// Scoreboard bench for pkt_ingress_ctrl: directed packets push expected
// buffer writes and commits; a negedge monitor pops and compares them.
module tb_pkt_ingress_ctrl;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tlast;
    logic               s_axis_tready;
    logic               buf_w_req_o;
    logic [DATA_W-1:0]  buf_w_data_o;
    logic               buf_r_req_o;
    logic               buf_empty_i;
    logic [DEPTH_W-1:0] pkt_len_o;
    logic               pkt_done_o;
    logic               ovf_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0]  q_wdata[$];
    logic [DEPTH_W-1:0] q_len[$];
    logic               q_ovf[$];

    // Simple packet-buffer model: fills on writes, drains one word per
    // cycle after a readout request. hold_full forces a non-empty flag.
    int   occ;
    logic draining;
    logic hold_full;

    assign buf_empty_i = (occ == 0) && !hold_full;

    always #5 clk = ~clk;

    pkt_ingress_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .buf_w_req_o   (buf_w_req_o),
        .buf_w_data_o  (buf_w_data_o),
        .buf_r_req_o   (buf_r_req_o),
        .buf_empty_i   (buf_empty_i),
        .pkt_len_o     (pkt_len_o),
        .pkt_done_o    (pkt_done_o),
        .ovf_err_o     (ovf_err_o)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 0;
            draining <= 1'b0;
        end else begin
            if (buf_r_req_o) draining <= 1'b1;
            else if (draining && occ == 0) draining <= 1'b0;
            if (buf_w_req_o) occ <= occ + 1;
            else if (draining && occ != 0) occ <= occ - 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write and every commit against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (buf_w_req_o) begin
                if (q_wdata.size() == 0) begin
                    chk("unexpected_write", {32'h0, buf_w_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("write_data", buf_w_data_o, q_wdata.pop_front());
                end
            end
            if (pkt_done_o) begin
                chk("rreq_with_done", buf_r_req_o, 1'b1);
                if (q_len.size() == 0) begin
                    chk("unexpected_commit", pkt_len_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("commit_len", pkt_len_o, q_len.pop_front());
                    chk("commit_ovf", ovf_err_o, q_ovf.pop_front());
                end
            end else begin
                if (buf_r_req_o) chk("rreq_without_done", buf_r_req_o, 1'b0);
                if (ovf_err_o)   chk("ovf_without_done", ovf_err_o, 1'b0);
            end
        end
    end

    task automatic push_commit(input int len, input logic ovf);
        q_len.push_back(DEPTH_W'(len));
        q_ovf.push_back(ovf);
    endtask

    // Present one beat and return #1 after the edge that accepts it
    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        int n;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 1'b1, 1'b0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        s_axis_tvalid = 1'b0;
        n = 0;
        while (!s_axis_tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", (n >= 200), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        hold_full     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wreq",  buf_w_req_o,  1'b0);
        chk("rst_wdata", buf_w_data_o, 32'h0);
        chk("rst_rreq",  buf_r_req_o,  1'b0);
        chk("rst_done",  pkt_done_o,   1'b0);
        chk("rst_ovf",   ovf_err_o,    1'b0);
        chk("rst_len",   pkt_len_o,    4'd0);
        chk("rst_ready", s_axis_tready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat with tlast in IDLE
        q_wdata.push_back(32'hA5A5_A5A5);
        push_commit(1, 1'b0);
        send(32'hA5A5_A5A5, 1'b1);
        s_axis_tvalid = 1'b0;
        chk("t1_wreq_p1",  buf_w_req_o,  1'b1);
        chk("t1_rreq_p1",  buf_r_req_o,  1'b0);
        chk("t1_ready_p1", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        chk("t1_rreq_p2", buf_r_req_o, 1'b1);
        chk("t1_done_p2", pkt_done_o,  1'b1);
        chk("t1_wreq_p2", buf_w_req_o, 1'b0);
        chk("t1_len_p2",  pkt_len_o,   4'd1);
        wait_idle();

        // Four words back to back
        for (int i = 1; i <= 4; i++) q_wdata.push_back(DATA_W'(i));
        push_commit(4, 1'b0);
        for (int i = 1; i <= 4; i++) send(DATA_W'(i), (i == 4));
        s_axis_tvalid = 1'b0;
        chk("t2_ready_commit", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        chk("t2_ready_drain", s_axis_tready, 1'b0);
        chk("t2_empty_drain", buf_empty_i,   1'b0);
        wait_idle();
        chk("t2_empty_at_ready", buf_empty_i, 1'b1);

        // Ten words into an eight-word buffer: truncated
        for (int i = 1; i <= 8; i++) q_wdata.push_back(DATA_W'(32'h100 + i));
        push_commit(8, 1'b1);
        for (int i = 1; i <= 10; i++) send(DATA_W'(32'h100 + i), (i == 10));
        wait_idle();

        // Exactly DEPTH words: no overflow
        for (int i = 1; i <= 8; i++) q_wdata.push_back(DATA_W'(32'h200 + i));
        push_commit(8, 1'b0);
        for (int i = 1; i <= 8; i++) send(DATA_W'(32'h200 + i), (i == 8));
        wait_idle();

        // Three words separated by 3-cycle tvalid gaps
        for (int i = 1; i <= 3; i++) q_wdata.push_back(DATA_W'(32'h300 + i));
        push_commit(3, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            send(DATA_W'(32'h300 + i), (i == 3));
            if (i < 3) idle_cycles(3);
        end
        wait_idle();
        chk("t5_wq_empty", q_wdata.size(), 0);
        chk("t5_cq_empty", q_len.size(),   0);

        // IDLE ready follows the buffer-empty flag; no writes while blocked
        hold_full = 1'b1;
        #1;
        chk("t6_ready_full", s_axis_tready, 1'b0);
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        hold_full     = 1'b0;
        #1;
        chk("t6_ready_empty", s_axis_tready, 1'b1);
        chk("t6_len_held",    pkt_len_o,     4'd3);

        // Reset after 2 of 5 beats
        q_wdata.push_back(32'h11);
        q_wdata.push_back(32'h22);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        s_axis_tvalid = 1'b0;
        #5;
        chk("t7_wreq_before_rst", buf_w_req_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("t7_wreq",  buf_w_req_o,  1'b0);
        chk("t7_wdata", buf_w_data_o, 32'h0);
        chk("t7_rreq",  buf_r_req_o,  1'b0);
        chk("t7_done",  pkt_done_o,   1'b0);
        chk("t7_ovf",   ovf_err_o,    1'b0);
        chk("t7_len",   pkt_len_o,    4'd0);
        chk("t7_ready", s_axis_tready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        q_wdata.push_back(32'h77);
        push_commit(1, 1'b0);
        send(32'h77, 1'b1);
        wait_idle();
        chk("t7_len_after", pkt_len_o, 4'd1);

        idle_cycles(2);
        chk("final_wq_empty", q_wdata.size(), 0);
        chk("final_cq_empty", q_len.size(),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
